// File: rtl/atomic_cnt_pkg.sv
// rtl/atomic_cnt_pkg.sv - shared types and constants for the atomic counter reader
package atomic_cnt_pkg;

    localparam int DATA_BUS  = 32;
    localparam int COUNT_LEN = 64;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_REQ_LO = 3'd1,
        ST_GAP    = 3'd2,
        ST_REQ_HI = 3'd3,
        ST_DONE   = 3'd4
    } rd_state_e;

    // Width of the per-beat timeout counter; never narrower than one bit.
    function automatic int tmo_width(input int timeout_cycles);
        return (timeout_cycles > 2) ? $clog2(timeout_cycles) : 1;
    endfunction

endpackage

// File: rtl/ack_timeout_cnt.sv
// rtl/ack_timeout_cnt.sv - per-beat acknowledge timeout counter
module ack_timeout_cnt
    import atomic_cnt_pkg::*;
#(
    parameter int TimeoutCycles = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    input  logic ack,
    output logic expired
);

    localparam int CntW = tmo_width(TimeoutCycles);
    localparam logic [CntW-1:0] LastCnt = CntW'(TimeoutCycles - 1);

    logic [CntW-1:0] cnt;

    // An ack in the final cycle wins over the timeout.
    assign expired = enable && !ack && (cnt == LastCnt);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt <= '0;
        end else if (enable && !ack && !expired) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/atomic_count_reader.sv
// rtl/atomic_count_reader.sv - two-beat atomic 64-bit counter snapshot reader
module atomic_count_reader
    import atomic_cnt_pkg::*;
#(
    parameter int DataBus       = DATA_BUS,
    parameter int CountLen      = COUNT_LEN,
    parameter int TimeoutCycles = 16
) (
    input  logic                clk_w,
    input  logic                reset_w,
    input  logic                rd_start_w_i,
    output logic                req_w_o,
    output logic                atomic_w_o,
    input  logic                ack_w_i,
    input  logic [DataBus-1:0]  count_w_i,
    output logic [CountLen-1:0] count_w_o,
    output logic                valid_w_o,
    input  logic                ready_w_i,
    output logic                busy_w_o,
    output logic                err_w_o
);

    rd_state_e state;
    rd_state_e state_nxt;
    logic      in_req;
    logic      tmo_expired;

    assign in_req = (state == ST_REQ_LO) || (state == ST_REQ_HI);

    ack_timeout_cnt #(
        .TimeoutCycles(TimeoutCycles)
    ) u_ack_timeout_cnt (
        .clk    (clk_w),
        .reset  (reset_w),
        .clear  (!in_req),
        .enable (in_req),
        .ack    (ack_w_i),
        .expired(tmo_expired)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (rd_start_w_i) state_nxt = ST_REQ_LO;
            ST_REQ_LO: begin
                if (ack_w_i)          state_nxt = ST_GAP;
                else if (tmo_expired) state_nxt = ST_IDLE;
            end
            ST_GAP:    state_nxt = ST_REQ_HI;
            ST_REQ_HI: begin
                if (ack_w_i)          state_nxt = ST_DONE;
                else if (tmo_expired) state_nxt = ST_IDLE;
            end
            ST_DONE:   if (ready_w_i) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so every port is a flop.
    always_ff @(posedge clk_w) begin
        if (reset_w) begin
            state      <= ST_IDLE;
            req_w_o    <= 1'b0;
            atomic_w_o <= 1'b0;
            valid_w_o  <= 1'b0;
            busy_w_o   <= 1'b0;
            err_w_o    <= 1'b0;
            count_w_o  <= '0;
        end else begin
            state      <= state_nxt;
            req_w_o    <= (state_nxt == ST_REQ_LO) || (state_nxt == ST_REQ_HI);
            atomic_w_o <= (state_nxt == ST_REQ_LO);
            valid_w_o  <= (state_nxt == ST_DONE);
            busy_w_o   <= (state_nxt != ST_IDLE);
            err_w_o    <= tmo_expired;
            if ((state == ST_REQ_LO) && ack_w_i) begin
                count_w_o[DataBus-1:0] <= count_w_i;
            end
            if ((state == ST_REQ_HI) && ack_w_i) begin
                count_w_o[CountLen-1:DataBus] <= count_w_i;
            end
        end
    end

endmodule

// File: doc/atomic_count_reader.md
# atomic_count_reader

Downstream consumer of the atomic 64-bit event counter. On a start pulse it performs the two-beat atomic read: low word with `atomic` asserted, then high word. It assembles the 64-bit snapshot and presents it to the control logic on a valid/ready handshake. A per-beat acknowledge timeout keeps a stalled counter from hanging the reader.

## Interface
Parameters:
- `DataBus`, 32, width of one counter read beat.
- `CountLen`, 64, assembled counter width; must equal 2*`DataBus`.
- `TimeoutCycles`, 16, maximum cycles `req_w_o` stays high per beat without ack; must be ≥2.

Ports:
- `clk_w`  in  1  single clock, rising edge.
- `reset_w`  in  1  synchronous, active-high reset.
- `rd_start_w_i`  in  1  one-cycle request to read the counter; ignored while `busy_w_o`=1.
- `req_w_o`  out  1  read request to counter; held until ack or timeout.
- `atomic_w_o`  out  1  high during the first (low-word) beat, low during the second.
- `ack_w_i`  in  1  counter acknowledge; `count_w_i` is valid in the same cycle.
- `count_w_i`  in  DataBus  counter read data.
- `count_w_o`  out  CountLen  assembled snapshot {high, low}.
- `valid_w_o`  out  1  `count_w_o` holds a complete snapshot.
- `ready_w_i`  in  1  consumer accepts the snapshot when high together with `valid_w_o`.
- `busy_w_o`  out  1  high in every state except IDLE.
- `err_w_o`  out  1  one-cycle pulse on ack timeout.

## Operation
- FSM states: IDLE, REQ_LO, GAP, REQ_HI, DONE.
- IDLE: all outputs 0. If `rd_start_w_i`=1, go to REQ_LO.
- REQ_LO: `req`=1, `atomic`=1.
  - On `ack_w_i`: latch `count_w_i` into `count_w_o[DataBus-1:0]` and go to GAP.
- GAP: `req`=0 for exactly one cycle, then go to REQ_HI. The counter requires `req` to drop between beats.
- REQ_HI: `req`=1, `atomic`=0.
  - On `ack_w_i`: latch `count_w_i` into `count_w_o[CountLen-1:DataBus]` and go to DONE.
- DONE: `valid_w_o`=1, `count_w_o` stable.
  - On `ready_w_i`: go to IDLE.
- Timeout, per beat:
  - The cycle counter clears on entry to REQ_LO or REQ_HI and increments each REQ cycle without ack.
  - If the counter equals `TimeoutCycles`-1 and `ack_w_i`=0 in that cycle: go to IDLE, assert `err_w_o` for one cycle, drop `req`. `count_w_o` keeps its prior value.
- Ignored inputs:
  - `ack_w_i` outside REQ_LO/REQ_HI.
  - `rd_start_w_i` while busy; no queuing.
  - `ready_w_i` outside DONE.
- Simultaneous events: ack in the final timeout cycle counts as success; no error.
- `count_w_o` changes only on ack latches; between reads it retains the last snapshot.

## Timing
- Reset values: state IDLE; `req_w_o`, `atomic_w_o`, `valid_w_o`, `busy_w_o`, `err_w_o` = 0; `count_w_o` = 0; timeout counter = 0.
- `reset_w` mid-read forces IDLE on the next edge. No error pulse; any partial low word is cleared to 0.
- All outputs are registered, with no combinational input-to-output path.
- `rd_start_w_i` sampled at edge T0 → `req_w_o`/`atomic_w_o` high from T1.
- Ack sampled at edge Tk in REQ_LO → GAP in Tk+1, REQ_HI (`req`=1, `atomic`=0) in Tk+2.
- Ack sampled in REQ_HI at edge Tm → `valid_w_o` high from Tm+1.
- Minimum start-to-valid latency is 4 cycles (immediate acks).
- A consumer holding `ready_w_i`=1 sees `valid_w_o` for exactly one cycle.
- `busy_w_o` drops in the cycle after the accepting handshake. A new start is accepted from that cycle.
- Timeout: `req` is held for at most `TimeoutCycles` cycles per beat. `err_w_o` is high in the cycle after the last `req` cycle.

## Structure
- Shared package `atomic_cnt_pkg`:
  - state enum `rd_state_e`.
  - default constants `DATA_BUS`=32 and `COUNT_LEN`=64.
  - timeout width function: $clog2(TimeoutCycles).
- Sub-module `ack_timeout_cnt`:
  - Inputs: `clear`, `enable`, `ack`.
  - Output: one-cycle `expired`.
  - Parameterised by `TimeoutCycles`.
  - Instantiated once.
- Top level contains the FSM, the data latches and the output registers.

## Test plan
- Basic read: counter holds 64'h0000_0001_DEAD_BEEF; acks arrive 2 cycles after each `req`; `ready`=1 → `count_w_o`=64'h0000_0001_DEAD_BEEF; `valid` for 1 cycle; `atomic`=1 on beat 1 only; exactly one GAP cycle.
- Back-pressure: `ready_w_i`=0 for 5 cycles after valid → `valid` and data stay stable 5 cycles; a start pulse during this window is ignored; `ready`=1 → IDLE next cycle.
- Timeout: `TimeoutCycles`=16, no ack on beat 2 → `req` high exactly 16 cycles; `err_w_o` pulses once; `valid` never rises; `count_w_o` unchanged.
- Ack on the last timeout cycle: ack at cycle 16 of beat 1 → no error; read completes normally.
- Reset mid-read: `reset_w` asserted during GAP → next cycle all outputs 0, `count_w_o`=0; a subsequent start reads 64'hFFFF_FFFF_0000_0000 correctly.
- Spurious inputs: ack pulses while IDLE; `rd_start` held high during REQ_HI → no extra beats; exactly one snapshot per accepted start.
